// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the ALU pipeline: packed instruction layout,
// ALU function codes, field widths and the issue scoreboard entry.
package alu_pipe_pkg;

  localparam int REG_W   = 4;
  localparam int ADDR_W  = 8;
  localparam int FUNC_W  = 4;
  localparam int INSTR_W = FUNC_W + 3 * REG_W + ADDR_W;

  // Field order matches the 24-bit instruction word, MSB first.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  // One in-flight destination register.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  // ALU function codes
  localparam logic [FUNC_W-1:0] ADD  = 4'd0;
  localparam logic [FUNC_W-1:0] SUB  = 4'd1;
  localparam logic [FUNC_W-1:0] MUL  = 4'd2;
  localparam logic [FUNC_W-1:0] AND  = 4'd3;
  localparam logic [FUNC_W-1:0] OR   = 4'd4;
  localparam logic [FUNC_W-1:0] XOR  = 4'd5;
  localparam logic [FUNC_W-1:0] NOR  = 4'd6;
  localparam logic [FUNC_W-1:0] NAND = 4'd7;
  localparam logic [FUNC_W-1:0] SLL  = 4'd8;
  localparam logic [FUNC_W-1:0] SRL  = 4'd9;
  localparam logic [FUNC_W-1:0] SRA  = 4'd10;
  localparam logic [FUNC_W-1:0] SLA  = 4'd11;
  localparam logic [FUNC_W-1:0] CMP  = 4'd12;
  localparam logic [FUNC_W-1:0] INC  = 4'd13;
  localparam logic [FUNC_W-1:0] DEC  = 4'd14;
  localparam logic [FUNC_W-1:0] NOP  = 4'd15;

  // True when the instruction reads register r as either source.
  function automatic logic reads_reg(input instr_t i, input logic [REG_W-1:0] r);
    return (i.rs1 == r) || (i.rs2 == r);
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous FIFO with occupancy count; no write-to-head bypass.
// Ports: clk, rst (sync, active-high), push/push_data (ignored when full),
// pop (ignored when empty), head (oldest entry), count (occupancy 0..DEPTH).
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Instruction issue front end for the four-stage ALU pipeline.
// Buffers instructions in a FIFO and issues at most one per cycle, inserting
// bubbles while the head reads a register still being written in flight.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_instr (push side);
// rs1/rs2/rd/func/addr + issue_valid (issued instruction, one cycle each);
// busy (work buffered or in flight); issue_cnt/stall_cnt (wrapping stats).
module alu_issue_unit
  import alu_pipe_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_instr,
  output logic [3:0]       rs1,
  output logic [3:0]       rs2,
  output logic [3:0]       rd,
  output logic [3:0]       func,
  output logic [7:0]       addr,
  output logic             issue_valid,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  logic [CNT_BITS-1:0] fifo_count;
  logic [INSTR_W-1:0]  head_bits;
  instr_t              head;
  logic                nonempty;
  logic                hazard;
  logic                issue;
  sb_entry_t           sb [HAZ_WIN];

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_instr),
    .pop       (issue),
    .head      (head_bits),
    .count     (fifo_count)
  );

  assign head     = instr_t'(head_bits);
  assign nonempty = (fifo_count != '0);
  assign in_ready = (fifo_count < CNT_BITS'(DEPTH));
  assign issue    = nonempty && !hazard;

  // The oldest scoreboard entry is completing write-back in the current
  // cycle, so its result is already readable; only the younger entries block.
  // This gives HAZ_WIN-k bubbles for a dependency issued k cycles earlier.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i + 1 < unsigned'(HAZ_WIN); i++) begin
      if (sb[i].v && reads_reg(head, sb[i].rd)) hazard = 1'b1;
    end
  end

  always_comb begin
    busy = nonempty;
    for (int unsigned i = 0; i < unsigned'(HAZ_WIN); i++) begin
      busy = busy | sb[i].v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < unsigned'(HAZ_WIN); i++) sb[i] <= '0;
    end else begin
      sb[0] <= '{v: issue, rd: head.rd};
      for (int unsigned i = 1; i < unsigned'(HAZ_WIN); i++) sb[i] <= sb[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func        <= '0;
      addr        <= '0;
      issue_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      issue_valid <= issue;
      if (issue) begin
        rs1       <= head.rs1;
        rs2       <= head.rs2;
        rd        <= head.rd;
        func      <= head.func;
        addr      <= head.addr;
        issue_cnt <= issue_cnt + 1'b1;
      end else if (nonempty) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
  import alu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        issue_valid;
  logic        busy;
  logic [3:0]  issue_cnt;
  logic [3:0]  stall_cnt;

  alu_issue_unit #(
    .DEPTH   (4),
    .HAZ_WIN (2),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .issue_valid (issue_valid),
    .busy        (busy),
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          ecount   = 0;
  logic [23:0] expq [$];
  int          issue_edges [$];
  int          exp_iss = 0;
  int          exp_stl = 0;
  int          t0;

  always @(posedge clk) ecount <= ecount + 1;

  // Scoreboard monitor: every issued instruction must match the oldest
  // expected entry, in order.
  always @(negedge clk) begin
    if (issue_valid) begin
      logic [23:0] got;
      logic [23:0] e;
      got = {func, rs1, rs2, rd, addr};
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue got=%h exp=none", got);
      end else begin
        e = expq.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL issue_fields got=%h exp=%h", got, e);
        end
      end
      issue_edges.push_back(ecount);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic [3:0] d,
                                     input logic [7:0] a);
    return {f, s1, s2, d, a};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [23:0] ins);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout got=in_ready_low exp=accept");
    end else begin
      expq.push_back(ins);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || expq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || expq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=busy%0d_pending%0d exp=idle", busy, expq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_issue_cnt"}, issue_cnt, 32'(exp_iss % 16));
    chk({tag, "_stall_cnt"}, stall_cnt, 32'(exp_stl % 16));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_issue_valid"}, issue_valid, 0);
    chk({tag, "_fields"}, {func, rs1, rs2, rd, addr}, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnts"}, {issue_cnt, stall_cnt}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b0;
    @(negedge clk);

    // Independent stream: issue on three consecutive edges, first issue one
    // edge after the accepting edge.
    issue_edges.delete();
    t0 = ecount;
    push(mk(ADD, 4'd3, 4'd5, 4'd10, 8'h10));
    push(mk(MUL, 4'd3, 4'd8, 4'd12, 8'h11));
    push(mk(SLA, 4'd7, 4'd3, 4'd13, 8'h12));
    drain();
    chk("indep_n", issue_edges.size(), 3);
    if (issue_edges.size() == 3) begin
      chk("indep_latency", issue_edges[0] - t0, 2);
      chk("indep_gap0", issue_edges[1] - issue_edges[0], 1);
      chk("indep_gap1", issue_edges[2] - issue_edges[1], 1);
    end
    exp_iss += 3;
    chk_counts("indep");

    // RAW through rs1, then through rs2: one bubble each.
    for (int v = 0; v < 2; v++) begin
      issue_edges.delete();
      push(mk(ADD, 4'd3, 4'd5, 4'd10, 8'h20));
      if (v == 0) push(mk(SUB, 4'd10, 4'd5, 4'd14, 8'h21));
      else        push(mk(SUB, 4'd5, 4'd10, 4'd14, 8'h22));
      drain();
      chk("raw_n", issue_edges.size(), 2);
      if (issue_edges.size() == 2) chk("raw_gap", issue_edges[1] - issue_edges[0], 2);
      exp_iss += 2;
      exp_stl += 1;
      chk_counts(v == 0 ? "raw_rs1" : "raw_rs2");
    end

    // Dependent chain: issue every other cycle so the FIFO fills.
    issue_edges.delete();
    for (int i = 0; i < 6; i++) push(mk(ADD, 4'(i + 1), 4'd0, 4'(i + 2), 8'(8'h30 + i)));
    chk("full_ready_cnt3", in_ready, 1);
    push(mk(ADD, 4'd7, 4'd0, 4'd8, 8'h36));
    chk("full_ready_low", in_ready, 0);
    chk("full_busy", busy, 1);
    t0 = ecount;
    push(mk(ADD, 4'd8, 4'd0, 4'd9, 8'h37));
    chk("full_wait", ecount - t0, 2);
    drain();
    chk("full_n", issue_edges.size(), 8);
    for (int i = 1; i < issue_edges.size(); i++) chk("full_gap", issue_edges[i] - issue_edges[i-1], 2);
    exp_iss += 8;
    exp_stl += 7;
    chk_counts("full");

    // Reset mid-stream with three entries queued; push on reset edge dropped.
    for (int i = 0; i < 6; i++) push(mk(XOR, 4'(i + 1), 4'd0, 4'(i + 2), 8'(8'h40 + i)));
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expq.delete();
    @(negedge clk);
    chk_reset_state("midrst");
    in_valid = 1'b1;
    in_instr = mk(ADD, 4'd1, 4'd2, 4'd3, 8'h55);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_no_issue", issue_valid, 0);
      chk("post_rst_busy", busy, 0);
      @(negedge clk);
    end
    exp_iss = 0;
    exp_stl = 0;
    chk_counts("post_rst");

    // Counter wrap: 17 independent issues on a 4-bit counter.
    for (int i = 0; i < 17; i++) push(mk(4'(i), 4'd1, 4'd2, 4'(4 + i % 8), 8'(i)));
    drain();
    chk("issue_cnt_wrap", issue_cnt, 1);
    exp_iss += 17;
    chk_counts("wrap");

    // Pointer wrap: 10 back-to-back independent issues, addr 125..134.
    issue_edges.delete();
    for (int i = 0; i < 10; i++) push(mk(4'(i), 4'd1, 4'd2, 4'(4 + i % 8), 8'(125 + i)));
    drain();
    chk("ptr_n", issue_edges.size(), 10);
    for (int i = 1; i < issue_edges.size(); i++) chk("ptr_gap", issue_edges[i] - issue_edges[i-1], 1);
    chk("ptr_last_addr", addr, 134);
    exp_iss += 10;
    chk_counts("ptr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
